// File: rtl/mc_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl_if : opcode/flag inputs and control outputs of mc_ctrl    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcwr;
  logic       irwr;
  logic       regwr;
  logic       memwr;
  logic [2:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [1:0] pcsrc;
  logic       done;
  logic [3:0] state;

  // master is the controller, slave is the datapath it steers
  modport master (
    input  op, funct, zero,
    output pcwr, irwr, regwr, memwr, aluop, alusrca, alusrcb, extop,
           regdst, memtoreg, pcsrc, done, state
  );
  modport slave (
    output op, funct, zero,
    input  pcwr, irwr, regwr, memwr, aluop, alusrca, alusrcb, extop,
           regdst, memtoreg, pcsrc, done, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS-subset control FSM (Moore decode)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DCD = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4,
    WBM = 4'd5, EXE = 4'd6, WBA = 4'd7, BR = 4'd8, JMP = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;

  state_t state_q;
  logic   is_rtype, is_r_alu, is_jr, is_i_alu, is_mem, is_jump, is_beq;

  always_comb begin
    is_rtype = (bus.op == OP_RTYPE);
    is_r_alu = is_rtype && (bus.funct == F_ADDU || bus.funct == F_SUBU ||
                            bus.funct == F_AND  || bus.funct == F_OR   ||
                            bus.funct == F_SLT);
    is_jr    = is_rtype && (bus.funct == F_JR);
    is_i_alu = (bus.op == OP_ADDIU) || (bus.op == OP_ORI) || (bus.op == OP_LUI);
    is_mem   = (bus.op == OP_LW) || (bus.op == OP_SW);
    is_jump  = (bus.op == OP_J) || (bus.op == OP_JAL) || is_jr;
    is_beq   = (bus.op == OP_BEQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: state_q <= DCD;
        DCD: begin
          if (is_mem)                     state_q <= MA;
          else if (is_r_alu || is_i_alu)  state_q <= EXE;
          else if (is_beq)                state_q <= BR;
          else if (is_jump)               state_q <= JMP;
          else                            state_q <= FETCH;
        end
        MA:      state_q <= (bus.op == OP_LW) ? MR : MW;
        MR:      state_q <= WBM;
        EXE:     state_q <= WBA;
        default: state_q <= FETCH;
      endcase
    end
  end

  logic       pcwr_d, irwr_d, regwr_d, memwr_d, done_d, alusrca_d, extop_d;
  logic [2:0] aluop_d;
  logic [1:0] alusrcb_d, regdst_d, memtoreg_d, pcsrc_d;

  always_comb begin
    pcwr_d     = 1'b0;
    irwr_d     = 1'b0;
    regwr_d    = 1'b0;
    memwr_d    = 1'b0;
    done_d     = 1'b0;
    alusrca_d  = 1'b0;
    extop_d    = 1'b0;
    aluop_d    = ALU_ADD;
    alusrcb_d  = 2'b00;
    regdst_d   = 2'b00;
    memtoreg_d = 2'b00;
    pcsrc_d    = 2'b00;
    case (state_q)
      FETCH: begin
        irwr_d    = 1'b1;
        pcwr_d    = 1'b1;
        alusrcb_d = 2'b01;
      end
      DCD: begin
        alusrcb_d = 2'b11;
        extop_d   = 1'b1;
        done_d    = !(is_mem || is_r_alu || is_i_alu || is_beq || is_jump);
      end
      MA: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
        extop_d   = 1'b1;
      end
      WBM: begin
        regwr_d    = 1'b1;
        memtoreg_d = 2'b01;
        done_d     = 1'b1;
      end
      MW: begin
        memwr_d = 1'b1;
        done_d  = 1'b1;
      end
      EXE: begin
        alusrca_d = 1'b1;
        if (is_rtype) begin
          case (bus.funct)
            F_SUBU:  aluop_d = ALU_SUB;
            F_AND:   aluop_d = ALU_AND;
            F_OR:    aluop_d = ALU_OR;
            F_SLT:   aluop_d = ALU_SLT;
            default: aluop_d = ALU_ADD;
          endcase
        end else begin
          alusrcb_d = 2'b10;
          case (bus.op)
            OP_ORI:  aluop_d = ALU_OR;
            OP_LUI:  aluop_d = ALU_LUI;
            default: begin aluop_d = ALU_ADD; extop_d = 1'b1; end
          endcase
        end
      end
      WBA: begin
        regwr_d  = 1'b1;
        regdst_d = is_rtype ? 2'b01 : 2'b00;
        done_d   = 1'b1;
      end
      BR: begin
        alusrca_d = 1'b1;
        aluop_d   = ALU_SUB;
        pcsrc_d   = 2'b01;
        pcwr_d    = bus.zero;
        done_d    = 1'b1;
      end
      JMP: begin
        pcwr_d  = 1'b1;
        done_d  = 1'b1;
        pcsrc_d = is_jr ? 2'b11 : 2'b10;
        if (bus.op == OP_JAL) begin
          regwr_d    = 1'b1;
          regdst_d   = 2'b10;
          memtoreg_d = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Enables are gated by rst directly so an abort takes effect before any clock edge
  assign bus.pcwr     = pcwr_d  & ~rst;
  assign bus.irwr     = irwr_d  & ~rst;
  assign bus.regwr    = regwr_d & ~rst;
  assign bus.memwr    = memwr_d & ~rst;
  assign bus.done     = done_d  & ~rst;
  assign bus.aluop    = aluop_d;
  assign bus.alusrca  = alusrca_d;
  assign bus.alusrcb  = alusrcb_d;
  assign bus.extop    = extop_d;
  assign bus.regdst   = regdst_d;
  assign bus.memtoreg = memtoreg_d;
  assign bus.pcsrc    = pcsrc_d;
  assign bus.state    = state_q;
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for mc_ctrl: spec-table vectors, random instruction stream, reset abort.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic pcwr, irwr, regwr, memwr;
    logic [2:0] aluop;
    logic alusrca;
    logic [1:0] alusrcb;
    logic extop;
    logic [1:0] regdst, memtoreg, pcsrc;
    logic done;
  } out_t;
  typedef logic [4:0][3:0] seq_t;
  typedef struct {
    string name;
    logic [5:0] op, funct;
    logic zero;
    int len;
    seq_t seq;
  } vec_t;

  localparam int C_LW = 0, C_SW = 1, C_RALU = 2, C_IALU = 3, C_BEQ = 4,
                 C_J = 5, C_JAL = 6, C_JR = 7, C_UND = 8;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic seq_t mkseq(int a, int b, int c, int d, int e);
    seq_t s;
    s[0] = a[3:0]; s[1] = b[3:0]; s[2] = c[3:0]; s[3] = d[3:0]; s[4] = e[3:0];
    return s;
  endfunction

  function automatic vec_t mkvec(string n, logic [5:0] o, logic [5:0] f, logic z, int l, seq_t s);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.zero = z; v.len = l; v.seq = s;
    return v;
  endfunction

  function automatic int cls(logic [5:0] op, logic [5:0] f);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b001001, 6'b001101, 6'b001111: return C_IALU;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b000000: begin
        if (f == 6'b001000) return C_JR;
        if (f == 6'b100001 || f == 6'b100011 || f == 6'b100100 ||
            f == 6'b100101 || f == 6'b101010) return C_RALU;
        return C_UND;
      end
      default: return C_UND;
    endcase
  endfunction

  // Latency and state walk per instruction class
  function automatic int len_of(int c);
    case (c)
      C_LW: return 5;
      C_SW, C_RALU, C_IALU: return 4;
      C_UND: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic seq_t seq_of(int c);
    case (c)
      C_LW:           return mkseq(0, 1, 2, 3, 5);
      C_SW:           return mkseq(0, 1, 2, 4, 0);
      C_RALU, C_IALU: return mkseq(0, 1, 6, 7, 0);
      C_BEQ:          return mkseq(0, 1, 8, 0, 0);
      C_UND:          return mkseq(0, 1, 0, 0, 0);
      default:        return mkseq(0, 1, 9, 0, 0);
    endcase
  endfunction

  function automatic out_t model(logic [3:0] st, logic [5:0] op, logic [5:0] f, logic z);
    out_t o;
    int c;
    o = '0;
    c = cls(op, f);
    case (st)
      4'd0: begin o.irwr = 1; o.pcwr = 1; o.alusrcb = 2'b01; end
      4'd1: begin o.alusrcb = 2'b11; o.extop = 1; o.done = (c == C_UND); end
      4'd2: begin o.alusrca = 1; o.alusrcb = 2'b10; o.extop = 1; end
      4'd4: begin o.memwr = 1; o.done = 1; end
      4'd5: begin o.regwr = 1; o.memtoreg = 2'b01; o.done = 1; end
      4'd6: begin
        o.alusrca = 1;
        if (c == C_RALU) begin
          o.aluop = (f == 6'b100011) ? 3'b001 : (f == 6'b100100) ? 3'b010 :
                    (f == 6'b100101) ? 3'b011 : (f == 6'b101010) ? 3'b100 : 3'b000;
        end else begin
          o.alusrcb = 2'b10;
          o.extop   = (op == 6'b001001);
          o.aluop   = (op == 6'b001101) ? 3'b011 : (op == 6'b001111) ? 3'b101 : 3'b000;
        end
      end
      4'd7: begin o.regwr = 1; o.done = 1; o.regdst = (c == C_RALU) ? 2'b01 : 2'b00; end
      4'd8: begin o.alusrca = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.pcwr = z; o.done = 1; end
      4'd9: begin
        o.pcwr = 1; o.done = 1;
        o.pcsrc = (c == C_JR) ? 2'b11 : 2'b10;
        if (c == C_JAL) begin o.regwr = 1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.pcwr = bus.pcwr; o.irwr = bus.irwr; o.regwr = bus.regwr; o.memwr = bus.memwr;
    o.aluop = bus.aluop; o.alusrca = bus.alusrca; o.alusrcb = bus.alusrcb;
    o.extop = bus.extop; o.regdst = bus.regdst; o.memtoreg = bus.memtoreg;
    o.pcsrc = bus.pcsrc; o.done = bus.done;
    return o;
  endfunction

  task automatic check_eq(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Enters with the DUT in FETCH just after a falling edge; leaves the same way
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] f, logic z,
                           bit rand_zero, seq_t seq, int ncyc);
    bus.op = op; bus.funct = f; bus.zero = z;
    for (int k = 0; k < ncyc; k++) begin
      #1;
      check_eq($sformatf("%s c%0d state", name, k), bus.state, seq[k]);
      check_eq($sformatf("%s c%0d outputs", name, k), dut_out(),
               model(seq[k], op, f, bus.zero));
      @(posedge clk);
      #1;
      if (rand_zero) bus.zero = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_quiet(string name);
    check_eq({name, " state"}, bus.state, 0);
    check_eq({name, " enables"},
             {bus.pcwr, bus.irwr, bus.regwr, bus.memwr, bus.done}, 0);
  endtask

  initial begin
    logic [5:0] op, f;
    int c;
    logic [5:0] ops [10];
    logic [5:0] fns [7];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001001, 6'b001101,
            6'b001111, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
    fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b001000, 6'b000000};

    vecs.push_back(mkvec("lw",     6'b100011, 6'd0,      1'b0, 5, mkseq(0, 1, 2, 3, 5)));
    vecs.push_back(mkvec("sw",     6'b101011, 6'd0,      1'b0, 4, mkseq(0, 1, 2, 4, 0)));
    vecs.push_back(mkvec("addu",   6'b000000, 6'b100001, 1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("subu",   6'b000000, 6'b100011, 1'b1, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("and",    6'b000000, 6'b100100, 1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("or",     6'b000000, 6'b100101, 1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("slt",    6'b000000, 6'b101010, 1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("addiu",  6'b001001, 6'd0,      1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("ori",    6'b001101, 6'd0,      1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("lui",    6'b001111, 6'd0,      1'b0, 4, mkseq(0, 1, 6, 7, 0)));
    vecs.push_back(mkvec("beq_z1", 6'b000100, 6'd0,      1'b1, 3, mkseq(0, 1, 8, 0, 0)));
    vecs.push_back(mkvec("beq_z0", 6'b000100, 6'd0,      1'b0, 3, mkseq(0, 1, 8, 0, 0)));
    vecs.push_back(mkvec("j",      6'b000010, 6'd0,      1'b0, 3, mkseq(0, 1, 9, 0, 0)));
    vecs.push_back(mkvec("jal",    6'b000011, 6'd0,      1'b1, 3, mkseq(0, 1, 9, 0, 0)));
    vecs.push_back(mkvec("jr",     6'b000000, 6'b001000, 1'b0, 3, mkseq(0, 1, 9, 0, 0)));
    vecs.push_back(mkvec("op3f",   6'b111111, 6'd0,      1'b0, 2, mkseq(0, 1, 0, 0, 0)));
    vecs.push_back(mkvec("rt_und", 6'b000000, 6'b000000, 1'b0, 2, mkseq(0, 1, 0, 0, 0)));

    // Reset: quiet with clock running
    rst = 1'b1; bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b1;
    #2;
    check_reset_quiet("reset_pre");
    repeat (2) @(posedge clk);
    #1;
    check_reset_quiet("reset_post_edge");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b0,
                vecs[i].seq, vecs[i].len);

    // Random instruction stream against the class model
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      c  = cls(op, f);
      run_instr($sformatf("rnd%0d_op%02h_f%02h", n, op, f), op, f, 1'($urandom),
                1'b1, seq_of(c), len_of(c));
    end

    // Reset pulse in MW must kill memwr at once
    run_instr("sw_abort", 6'b101011, 6'd0, 1'b0, 1'b0, mkseq(0, 1, 2, 4, 0), 3);
    #1;
    check_eq("abort MW state", bus.state, 4);
    check_eq("abort MW memwr", bus.memwr, 1);
    rst = 1'b1;
    #1;
    check_eq("abort memwr drop", bus.memwr, 0);
    check_reset_quiet("abort async");
    @(posedge clk);
    #1;
    check_reset_quiet("abort held");
    @(negedge clk);
    rst = 1'b0;
    run_instr("lw_after_abort", 6'b100011, 6'd0, 1'b0, 1'b0, mkseq(0, 1, 2, 3, 5), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op  input  6  opcode, IR[31:26]; stable from the cycle after FETCH until the next FETCH.
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag, same cycle.
REQ-007 pcwr, irwr, regwr, memwr  output  1 each  PC, IR, register-file and memory write enables.
REQ-008 aluop  output  3  ALU operation: ADD=000, SUB=001, AND=010, OR=011, SLT=100, LUI=101, EQB=110.
REQ-009 alusrca  output  1  ALU A select: 0=PC, 1=rs register.
REQ-010 alusrcb  output  2  ALU B select: 00=rt, 01=const 4, 10=ext(imm), 11=sext(imm)<<2.
REQ-011 extop  output  1  immediate extend: 1=sign, 0=zero.
REQ-012 regdst  output  2  write register: 00=rt, 01=rd, 10=31.
REQ-013 memtoreg  output  2  writeback source: 00=ALUOut, 01=MDR, 10=PC.
REQ-014 pcsrc  output  2  next PC: 00=ALU result, 01=ALUOut (branch target), 10=jump target, 11=rs.
REQ-015 done  output  1  one-cycle pulse in the last cycle of every instruction.
REQ-016 state  output  4  current state code, for debug.

Function
REQ-017 Moore FSM; outputs decode combinationally from state, op and funct; the only exception is pcwr in BR, which equals zero.
REQ-018 States: FETCH=0, DCD=1, MA=2, MR=3, MW=4, WBM=5, EXE=6, WBA=7, BR=8, JMP=9; codes 10-15 go to FETCH on the next edge with all enables 0.
REQ-019 Any output not listed for a state is 0 (enables) or 00/000 (selects).
REQ-020 FETCH: irwr=1, pcwr=1, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00; next state DCD.
REQ-021 DCD: alusrca=0, alusrcb=11, aluop=ADD, extop=1 (branch target precompute).
REQ-022 DCD next state: lw(100011)/sw(101011)->MA; R-type(000000) with funct in {addu 100001, subu 100011, and 100100, or 100101, slt 101010} -> EXE; R-type with funct jr(001000) -> JMP; addiu(001001), ori(001101), lui(001111) -> EXE; beq(000100)->BR; j(000010)/jal(000011)->JMP; any other op or funct -> FETCH with no write, done=1.
REQ-023 MA: alusrca=1, alusrcb=10, extop=1, aluop=ADD; next state MR for lw, MW for sw.
REQ-024 MR: no enables; next state WBM.
REQ-025 WBM: regwr=1, regdst=00, memtoreg=01, done=1; next state FETCH.
REQ-026 MW: memwr=1, done=1; next state FETCH.
REQ-027 EXE, R-type: alusrca=1, alusrcb=00; aluop from funct: addu->ADD, subu->SUB, and->AND, or->OR, slt->SLT.
REQ-028 EXE, I-type: alusrca=1, alusrcb=10; addiu: extop=1, ADD; ori: extop=0, OR; lui: extop=0, LUI. Next state WBA.
REQ-029 WBA: regwr=1, memtoreg=00, regdst=01 for R-type and 00 for I-type, done=1; next state FETCH.
REQ-030 BR: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, pcwr=zero, done=1; next state FETCH.
REQ-031 JMP: pcwr=1, done=1; j: pcsrc=10; jal: pcsrc=10, regwr=1, regdst=10, memtoreg=10; jr: pcsrc=11; next state FETCH.
REQ-032 Latency in cycles, counting FETCH: lw 5; sw, R-type ALU, I-type ALU 4; beq, j, jal, jr 3; undefined 2.
REQ-033 At most one of regwr and memwr is asserted in any cycle; irwr is asserted only in FETCH.

Reset
REQ-034 While rst=1: state=FETCH, and all enables (pcwr, irwr, regwr, memwr, done) are forced to 0 regardless of clk.
REQ-035 The first rising edge with rst=0 executes FETCH.
REQ-036 Reset asserted mid-instruction aborts it immediately; no partial write occurs after rst rises.

Verification
REQ-037 Reset, then lw (op=100011) -> states 0,1,2,3,5,0; regwr=1 and memtoreg=01 only in state 5; done in state 5.
REQ-038 addu (op=0, funct=100001) -> states 0,1,6,7; aluop=000, alusrcb=00 in state 6; regdst=01 in state 7.
REQ-039 beq with zero=1 vs. zero=0 -> states 0,1,8; pcwr=1 and 0 respectively, pcsrc=01 in both cases.
REQ-040 jal -> states 0,1,9; regwr=1, regdst=10, memtoreg=10, pcsrc=10 in state 9; jr -> pcsrc=11, regwr=0.
REQ-041 op=111111 -> states 0,1,0; no regwr or memwr, done=1 in state 1.
REQ-042 rst pulsed asynchronously during MW -> memwr drops in the same cycle; state=0 with rst still high.
